// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the instruction fetch controller.
//   fc_state_e  - controller FSM states (IDLE / LOAD / RUN / HALT)
//   FC_ADDR_W   - default instruction memory address width (words)
//   FC_DATA_W   - default instruction word width
package fetch_pkg;

  localparam int unsigned FC_ADDR_W = 10;
  localparam int unsigned FC_DATA_W = 32;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_LOAD = 2'd1,
    FC_RUN  = 2'd2,
    FC_HALT = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program counter register for the fetch controller.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (pc <= RESET_PC)
//   set_start     - reload pc with RESET_PC (entering RUN)
//   redirect_en   - load pc from redirect_addr
//   redirect_addr - redirect target
//   advance       - increment pc (wraps modulo 2**ADDR_W)
//   pc            - current program counter
// Priority: set_start > redirect_en > advance > hold.
module fetch_pc_gen #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_start,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= START_PC;
    end else if (set_start) begin
      pc <= START_PC;
    end else if (redirect_en) begin
      pc <= redirect_addr;
    end else if (advance) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the single instruction memory port. Preloads program
// words from a loader (LOAD), then issues sequential fetches (RUN) with stall,
// redirect and halt control. The memory has a 1-cycle registered read, so
// instr_valid/instr_pc are registered to line up with the returned data.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   load_start, run_start        - IDLE: enter LOAD / enter RUN
//   load_valid/addr/data/done    - loader word interface; load_ready high in LOAD
//   stall, redirect_valid/addr   - pipeline control in RUN
//   halt_req                     - enter sticky HALT; halted reports it
//   imem_addr/wdata/we           - combinational memory port
//   instr_valid, instr_pc        - read data this cycle is a live instruction at instr_pc
// Optional (macro FETCH_CTRL_PERF_EN): fetch_count, bubble_count saturating
//   counters of issue cycles and non-issue RUN cycles.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = FC_ADDR_W,
  parameter int unsigned DATA_W   = FC_DATA_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              imem_we,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count
`endif
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

  fc_state_e         state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              in_run;
  logic              issue;
  logic              set_start;
  logic              redirect_en;

  assign in_run      = (state == FC_RUN);
  assign issue       = in_run && !stall && !redirect_valid && !halt_req;
  assign redirect_en = in_run && !halt_req && redirect_valid;
  assign set_start   = ((state == FC_IDLE) && !load_start && run_start) ||
                       ((state == FC_LOAD) && load_done);
  assign halted      = (state == FC_HALT);

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .set_start     (set_start),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .advance       (issue),
    .pc            (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FC_IDLE;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nxt;
      instr_valid <= issue;
      if (issue) begin
        instr_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FC_IDLE: begin
        if (load_start) begin
          state_nxt = FC_LOAD;
        end else if (run_start) begin
          state_nxt = FC_RUN;
        end
      end
      FC_LOAD: if (load_done) state_nxt = FC_RUN;
      FC_RUN:  if (halt_req)  state_nxt = FC_HALT;
      FC_HALT: state_nxt = FC_HALT;
      default: state_nxt = FC_IDLE;
    endcase
  end

  // Reset overrides the port combinationally so a write presented in the
  // reset cycle never reaches memory.
  always_comb begin
    imem_addr  = pc;
    imem_wdata = '0;
    imem_we    = 1'b0;
    load_ready = 1'b0;
    if (rst) begin
      imem_addr = START_PC;
    end else if (state == FC_LOAD) begin
      imem_addr  = load_addr;
      imem_wdata = load_data;
      imem_we    = load_valid;
      load_ready = 1'b1;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (issue && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (in_run && !issue && (bubble_count != '1)) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, run_start, load_valid, load_done;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        stall, redirect_valid, halt_req;
  logic [9:0]  redirect_addr;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we, instr_valid, halted;
  logic [9:0]  instr_pc;

  // second instance, RESET_PC = 1023, for the wrap case
  logic        run_start2, halt_req2;
  logic        load_ready2, imem_we2, instr_valid2, halted2;
  logic [9:0]  imem_addr2, instr_pc2;
  logic [31:0] imem_wdata2;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_count, bubble_count, fetch_count2, bubble_count2;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] rdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    rdata <= mem[imem_addr];
  end

  fetch_controller #(.ADDR_W(10), .DATA_W(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_ready(load_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt_req(halt_req), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_we(imem_we), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .halted(halted)
`ifdef FETCH_CTRL_PERF_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  fetch_controller #(.ADDR_W(10), .DATA_W(32), .RESET_PC(1023)) dut2 (
    .clk(clk), .rst(rst), .load_start(1'b0), .run_start(run_start2),
    .load_valid(1'b0), .load_addr(10'd0), .load_data(32'd0),
    .load_done(1'b0), .load_ready(load_ready2), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_addr(10'd0),
    .halt_req(halt_req2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .imem_we(imem_we2), .instr_valid(instr_valid2), .instr_pc(instr_pc2),
    .halted(halted2)
`ifdef FETCH_CTRL_PERF_EN
    , .fetch_count(fetch_count2), .bubble_count(bubble_count2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst = 1'b1; load_start = 1'b0; run_start = 1'b0; load_valid = 1'b0;
    load_done = 1'b0; load_addr = '0; load_data = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; halt_req = 1'b0;
    run_start2 = 1'b0; halt_req2 = 1'b0;
    load_valid = 1'b1; load_addr = 10'd9; load_data = 32'hBAD;

    tick(); tick();
    check("rst_we", {31'd0, imem_we}, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_addr", {22'd0, imem_addr}, 0);
    check("rst_ready", {31'd0, load_ready}, 0);
    check("rst_ivalid", {31'd0, instr_valid}, 0);
    check("rst_ipc", {22'd0, instr_pc}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_addr2", {22'd0, imem_addr2}, 1023);

    // IDLE: load inputs ignored
    rst = 1'b0; #1;
    check("idle_we", {31'd0, imem_we}, 0);
    load_start = 1'b1; run_start = 1'b1; run_start2 = 1'b1;
    tick();
    load_start = 1'b0; run_start = 1'b0; run_start2 = 1'b0;
    check("load_ready", {31'd0, load_ready}, 1);
    check("run2_addr", {22'd0, imem_addr2}, 1023);

    // LOAD four words
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_addr = 10'(i); load_data = 32'h11 * (i + 1);
      load_done = (i == 3); #1;
      check("load_we", {31'd0, imem_we}, 1);
      check("load_addr", {22'd0, imem_addr}, i);
      check("load_wdata", imem_wdata, 32'h11 * (i + 1));
      tick();
      if (i == 0) begin
        check("wrap_ivalid_a", {31'd0, instr_valid2}, 1);
        check("wrap_ipc_a", {22'd0, instr_pc2}, 1023);
      end
      if (i == 1) begin
        check("wrap_ivalid_b", {31'd0, instr_valid2}, 1);
        check("wrap_ipc_b", {22'd0, instr_pc2}, 0);
        halt_req2 = 1'b1;
      end
    end
    load_valid = 1'b0; load_done = 1'b0;

    // RUN from 0
    check("run_ready", {31'd0, load_ready}, 0);
    check("run_addr0", {22'd0, imem_addr}, 0);
    check("run_we", {31'd0, imem_we}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_ivalid", {31'd0, instr_valid}, 1);
      check("seq_ipc", {22'd0, instr_pc}, i);
      check("seq_data", rdata, 32'h11 * (i + 1));
    end
    check("halted2", {31'd0, halted2}, 1);

    // stall two cycles
    stall = 1'b1;
    tick(); check("stall_iv1", {31'd0, instr_valid}, 0);
    tick(); check("stall_iv2", {31'd0, instr_valid}, 0);
    stall = 1'b0;
    tick();
    check("post_stall_iv", {31'd0, instr_valid}, 1);
    check("post_stall_pc", {22'd0, instr_pc}, 3);
    check("post_stall_data", rdata, 32'h44);
    tick();
    check("pc4_pc", {22'd0, instr_pc}, 4);

    // redirect at pc=5
    check("pre_redir_addr", {22'd0, imem_addr}, 5);
    redirect_valid = 1'b1; redirect_addr = 10'd100;
    tick();
    redirect_valid = 1'b0; redirect_addr = 10'd0;
    check("redir_bubble", {31'd0, instr_valid}, 0);
    check("redir_addr", {22'd0, imem_addr}, 100);
    tick();
    check("redir_iv100", {31'd0, instr_valid}, 1);
    check("redir_pc100", {22'd0, instr_pc}, 100);
    tick();
    check("redir_pc101", {22'd0, instr_pc}, 101);

    // halt with redirect and stall in the same cycle
    redirect_valid = 1'b1; redirect_addr = 10'd7; stall = 1'b1; halt_req = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0; halt_req = 1'b0;
    check("halt_halted", {31'd0, halted}, 1);
    check("halt_iv", {31'd0, instr_valid}, 0);
    load_start = 1'b1; run_start = 1'b1; load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_sticky", {31'd0, halted}, 1);
      check("halt_no_iv", {31'd0, instr_valid}, 0);
      check("halt_no_we", {31'd0, imem_we}, 0);
      check("halt_no_ready", {31'd0, load_ready}, 0);
    end
    load_start = 1'b0; run_start = 1'b0; load_valid = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
    // issues: 0,1,2,3,4,100,101; bubbles: 2 stall, 1 redirect, 1 halt
    check("perf_fetch", fetch_count, 7);
    check("perf_bubble", bubble_count, 4);
    check("perf_fetch2", fetch_count2, 2);
`endif

    // reset in the middle of LOAD
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_halted", {31'd0, halted}, 0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_addr = 10'd5; load_data = 32'hDEAD; #1;
    check("midload_we_pre", {31'd0, imem_we}, 1);
    rst = 1'b1; #1;
    check("midload_rst_we", {31'd0, imem_we}, 0);
    check("midload_rst_ready", {31'd0, load_ready}, 0);
    tick();
    rst = 1'b0; #1;
    check("midload_idle_ready", {31'd0, load_ready}, 0);
    check("midload_idle_we", {31'd0, imem_we}, 0);
    check("midload_mem5", mem[5], 0);
    load_valid = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
    check("perf_rst", fetch_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
